// File: rtl/pio_cmd_bridge.sv
// pio_cmd_bridge
//   Bridges HPS PIO writes into a queue of coprocessor commands. Each trigger
//   on pio_enable_export pushes pio_instruct_export into a FIFO. Commands are
//   issued one at a time over a valid/ready handshake. After each handshake
//   the bridge waits for cp_done (optionally bounded by a timeout) before it
//   issues the next command. The outcome is kept in a sticky status word.
//
// Ports
//   clk_clk, reset_reset_n  clock and asynchronous active-low reset
//   pio_instruct_export     instruction word from the HPS
//   pio_enable_export       trigger (rising edge or toggle, see EN_MODE)
//   pio_flags_export        {BUSY, FULL, ERROR, DONE}
//   cmd_data/valid/ready    command handshake to the coprocessor
//   cp_done, cp_err         completion pulse and its error qualifier
//   fifo_count              queue occupancy
//   overflow                one-cycle pulse when a trigger is dropped
module pio_cmd_bridge #(
   parameter int INSTR_W     = 29,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 3,
   parameter int EN_MODE     = 0,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [INSTR_W-1:0] pio_instruct_export,
   input  logic               pio_enable_export,
   output logic [3:0]         pio_flags_export,
   output logic [INSTR_W-1:0] cmd_data,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   input  logic               cp_done,
   input  logic               cp_err,
   output logic [CNT_W-1:0]   fifo_count,
   output logic               overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // The counter only has to reach TIMEOUT_CYC-1. It is at least one bit wide.
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 2);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               en_q, done_q, done_d, err_q, err_d, full_q, ovf_q;
   logic               trig, full, pop, push, drop, tmo_hit;

   assign trig = (EN_MODE != 0) ? (pio_enable_export ^ en_q)
                                : (pio_enable_export & ~en_q);
   assign full = (cnt_q == CNT_W'(DEPTH));
   assign pop  = (state_q == S_ISSUE) & cmd_ready;
   // A pop on the same edge frees a slot, so a push into a full queue still
   // succeeds in that case.
   assign push = trig & (~full | pop);
   assign drop = trig & full & ~pop;
   assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

   assign tmo_hit = (TIMEOUT_CYC != 0) && (state_q == S_WAIT) && !cp_done &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      done_d  = done_q;
      err_d   = err_q;
      // A new command clears the status. Any set condition below overrides it.
      if (push) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      case (state_q)
         S_IDLE:  if (cnt_q != '0) state_d = S_ISSUE;
         S_ISSUE: if (cmd_ready) begin
            state_d = S_WAIT;
            tmo_d   = '0;
         end
         S_WAIT: begin
            if (cp_done) begin
               done_d = 1'b1;
               if (cp_err) err_d = 1'b1;
               // Include a push on this same edge, so no idle bubble is inserted.
               state_d = (cnt_d != '0) ? S_ISSUE : S_IDLE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (drop) err_d = 1'b1;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_q + PTR_W'(push);
         rptr_q  <= rptr_q + PTR_W'(pop);
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         en_q    <= pio_enable_export;
         done_q  <= done_d;
         err_q   <= err_d;
         full_q  <= (cnt_d == CNT_W'(DEPTH));
         ovf_q   <= drop;
      end
   end

   // Storage needs no reset. The pointers and the count define its contents.
   always_ff @(posedge clk_clk) begin
      if (push) mem_q[wptr_q] <= pio_instruct_export;
   end

   assign cmd_valid        = (state_q == S_ISSUE);
   assign cmd_data         = cmd_valid ? mem_q[rptr_q] : '0;
   assign fifo_count       = cnt_q;
   assign overflow         = ovf_q;
   assign pio_flags_export = {(state_q != S_IDLE) | (cnt_q != '0), full_q, err_q, done_q};

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Bench for pio_cmd_bridge. It drives two instances from shared stimulus:
//   u0: EN_MODE=0 (rising edge), TIMEOUT_CYC=16
//   u1: EN_MODE=1 (toggle),      TIMEOUT_CYC=0
// A behavioural model (a list of pushed words, write/read totals, a phase
// number) predicts every output of both instances. Directed literal checks
// pin the model to hand-computed values.
module tb_pio_cmd_bridge;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [28:0] instr = '0;
   logic        en = 1'b0, rdy = 1'b0, cpd = 1'b0, cpe = 1'b0;

   logic [3:0]  a_flags [2];
   logic [28:0] a_data  [2];
   logic        a_valid [2];
   logic [2:0]  a_cnt   [2];
   logic        a_ovf   [2];

   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   pio_cmd_bridge #(.INSTR_W(29), .DEPTH(4), .CNT_W(3), .EN_MODE(0), .TIMEOUT_CYC(16)) u0 (
      .clk_clk(clk), .reset_reset_n(rst_n), .pio_instruct_export(instr),
      .pio_enable_export(en), .pio_flags_export(a_flags[0]), .cmd_data(a_data[0]),
      .cmd_valid(a_valid[0]), .cmd_ready(rdy), .cp_done(cpd), .cp_err(cpe),
      .fifo_count(a_cnt[0]), .overflow(a_ovf[0]));

   pio_cmd_bridge #(.INSTR_W(29), .DEPTH(4), .CNT_W(3), .EN_MODE(1), .TIMEOUT_CYC(0)) u1 (
      .clk_clk(clk), .reset_reset_n(rst_n), .pio_instruct_export(instr),
      .pio_enable_export(en), .pio_flags_export(a_flags[1]), .cmd_data(a_data[1]),
      .cmd_valid(a_valid[1]), .cmd_ready(rdy), .cp_done(cpd), .cp_err(cpe),
      .fifo_count(a_cnt[1]), .overflow(a_ovf[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase: 0 = idle, 1 = offering a command, 2 = waiting for completion.
   int          M_MODE [2] = '{0, 1};
   int          M_TO   [2] = '{16, 0};
   logic [28:0] m_buf  [2][64];
   int          m_wr [2], m_rd [2], m_ph [2], m_tmo [2];
   bit          m_done [2], m_err [2], m_ovf [2], m_en [2];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_wr[i] = 0; m_rd[i] = 0; m_ph[i] = 0; m_tmo[i] = 0;
            m_done[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_en[i] = 0;
         end else begin
            bit trig, pop, push;
            int occ;
            trig = (M_MODE[i] != 0) ? (en ^ m_en[i]) : (en & ~m_en[i]);
            occ  = m_wr[i] - m_rd[i];
            pop  = (m_ph[i] == 1) && rdy;
            m_ovf[i] = trig && (occ == 4) && !pop;
            push = trig && !m_ovf[i];
            if (push) begin
               m_buf[i][m_wr[i] % 64] = instr;
               m_wr[i]++;
               m_done[i] = 0;
               m_err[i]  = 0;
            end
            if (pop) m_rd[i]++;
            if (m_ovf[i]) m_err[i] = 1;
            case (m_ph[i])
               0: if (occ != 0) m_ph[i] = 1;
               1: if (rdy) begin m_ph[i] = 2; m_tmo[i] = 0; end
               default: begin
                  if (cpd) begin
                     m_done[i] = 1;
                     if (cpe) m_err[i] = 1;
                     m_ph[i] = (m_wr[i] != m_rd[i]) ? 1 : 0;
                  end else if (M_TO[i] > 0) begin
                     m_tmo[i]++;
                     if (m_tmo[i] == M_TO[i]) begin
                        m_err[i] = 1;
                        m_ph[i]  = 0;
                     end
                  end
               end
            endcase
            m_en[i] = en;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int occ;
         logic [3:0] ef;
         occ = m_wr[i] - m_rd[i];
         ef  = {(m_ph[i] != 0) || (occ != 0), occ == 4, m_err[i], m_done[i]};
         chk($sformatf("m_flags%0d", i), a_flags[i], ef);
         chk($sformatf("m_valid%0d", i), a_valid[i], m_ph[i] == 1);
         chk($sformatf("m_data%0d", i), a_data[i], (m_ph[i] == 1) ? m_buf[i][m_rd[i] % 64] : 29'd0);
         chk($sformatf("m_count%0d", i), a_cnt[i], occ);
         chk($sformatf("m_ovf%0d", i), a_ovf[i], m_ovf[i]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int c;
      rdy = 1'b1;
      cpd = 1'b0;
      c = 0;
      while (c < 200 && (a_flags[0][3] || a_flags[1][3])) begin
         cpd = ~cpd;
         tick();
         c++;
      end
      rdy = 1'b0;
      cpd = 1'b0;
      chk("drain_idle", {a_flags[0][3], a_flags[1][3]}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("rst_flags", a_flags[i], 4'b0000);
         chk("rst_valid", a_valid[i], 1'b0);
         chk("rst_count", a_cnt[i], 3'd0);
      end

      // Single command, 2-edge latency, then DONE.
      instr = 29'h1ABCDEF;
      en = 1'b1;
      tick();
      chk("lat_not_yet", a_valid[0], 1'b0);
      tick();
      chk("lat_valid", a_valid[0], 1'b1);
      chk("lat_data", a_data[0], 29'h1ABCDEF);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      chk("wait_valid_low", a_valid[0], 1'b0);
      cpd = 1'b1;
      tick();
      cpd = 1'b0;
      chk("done_flags0", a_flags[0], 4'b0001);
      chk("done_flags1", a_flags[1], 4'b0001);

      // Fill dut0 to DEPTH, overflow, then drain in order.
      en = 1'b0;
      tick();
      for (int k = 1; k <= 4; k++) begin
         instr = 29'(k);
         en = 1'b1;
         tick();
         en = 1'b0;
         tick();
      end
      chk("fill_count", a_cnt[0], 3'd4);
      chk("fill_full", a_flags[0][2], 1'b1);
      instr = 29'd5;
      en = 1'b1;
      tick();
      chk("ovf_pulse", a_ovf[0], 1'b1);
      chk("ovf_flags", a_flags[0], 4'b1110);
      chk("ovf_count", a_cnt[0], 3'd4);
      en = 1'b0;
      tick();
      chk("ovf_one_cycle", a_ovf[0], 1'b0);
      for (int k = 1; k <= 4; k++) begin
         chk("order_valid", a_valid[0], 1'b1);
         chk("order_data", a_data[0], 29'(k));
         rdy = 1'b1;
         tick();
         rdy = 1'b0;
         cpd = 1'b1;
         tick();
         cpd = 1'b0;
      end
      chk("order_empty", a_cnt[0], 3'd0);
      drain();

      // Toggle mode: three transitions give three commands in dut1, two in dut0.
      en = 1'b1; tick();
      en = 1'b0; tick();
      en = 1'b1; tick();
      repeat (3) tick();
      chk("toggle_count1", a_cnt[1], 3'd3);
      chk("toggle_count0", a_cnt[0], 3'd2);
      drain();

      // Error on completion, ignored done/err in idle, clear on next push.
      en = 1'b0; tick();
      drain();
      en = 1'b1; rdy = 1'b1;
      repeat (3) tick();
      rdy = 1'b0;
      cpd = 1'b1; cpe = 1'b1;
      tick();
      cpd = 1'b0; cpe = 1'b0;
      chk("err_flags", a_flags[0], 4'b0011);
      cpd = 1'b1; tick(); cpd = 1'b0;
      cpe = 1'b1; tick(); cpe = 1'b0;
      chk("idle_done_ignored", a_flags[0], 4'b0011);
      en = 1'b0; tick();
      en = 1'b1; tick();
      chk("push_clears", a_flags[0], 4'b1000);
      drain();

      // Timeout in dut0: ERROR 16 edges after WAIT entry.
      rdy = 1'b1;
      en = 1'b0; tick();
      en = 1'b1;
      repeat (3) tick();
      rdy = 1'b0;
      repeat (15) tick();
      chk("tmo_before", a_flags[0], 4'b1000);
      tick();
      chk("tmo_after", a_flags[0], 4'b0010);
      drain();

      // Async reset with one command in WAIT and three queued.
      en = 1'b0; tick();
      en = 1'b1; rdy = 1'b1;
      repeat (3) tick();
      rdy = 1'b0;
      repeat (3) begin
         en = 1'b0; tick();
         en = 1'b1; tick();
      end
      chk("pre_rst_count", a_cnt[0], 3'd3);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("arst_flags", a_flags[i], 4'b0000);
         chk("arst_valid", a_valid[i], 1'b0);
         chk("arst_data", a_data[i], 29'd0);
         chk("arst_count", a_cnt[i], 3'd0);
         chk("arst_ovf", a_ovf[i], 1'b0);
      end
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_count", a_cnt[i], 3'd0);
         chk("post_rst_valid", a_valid[i], 1'b0);
      end

      // Random traffic, checked by the model every cycle.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 3) == 0) en = ~en;
         instr = 29'($urandom);
         rdy   = 1'($urandom_range(0, 1));
         cpd   = ($urandom_range(0, 3) == 0);
         cpe   = 1'($urandom_range(0, 1));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/pio_cmd_bridge.md
Name: pio_cmd_bridge

Overview:
- Parametrised HPS-to-fabric command bridge on the lightweight PIO path: pio_instruct/pio_enable in, pio_flags out.
- Turns software enable events into queued commands and issues them one at a time to a coprocessor over a valid/ready handshake.
- Tracks completion, errors and timeouts, and reports them in a sticky status word that software polls.
- Generalises the fixed 29-bit/1-shot PIO scheme: configurable width and queue depth, a toggle trigger mode, overflow and timeout detection.

Parameters:
- INSTR_W, 29: instruction width.
- DEPTH, 4: command FIFO depth; power of 2, 2..64.
- CNT_W, 3: fifo_count width; must satisfy 2^CNT_W > DEPTH.
- EN_MODE, 0: trigger mode. 0 = rising edge of pio_enable_export; 1 = any toggle of pio_enable_export.
- TIMEOUT_CYC, 0: maximum WAIT cycles before a timeout error; 0 disables the timeout.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- pio_instruct_export  in  INSTR_W  instruction word from the HPS PIO.
- pio_enable_export  in  1  trigger from the HPS PIO; synchronous to clk_clk.
- pio_flags_export  out  4  status: [0] DONE, [1] ERROR, [2] FULL, [3] BUSY.
- cmd_data  out  INSTR_W  command to the coprocessor.
- cmd_valid  out  1  cmd_data valid.
- cmd_ready  in  1  coprocessor accepts the command.
- cp_done  in  1  one-cycle completion pulse from the coprocessor.
- cp_err  in  1  error qualifier; sampled only together with cp_done.
- fifo_count  out  CNT_W  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when a command is dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, en_q=0, state IDLE, timeout counter 0. Reset is effective immediately mid-operation; queued commands are discarded.
- Trigger (trig):
  - EN_MODE=0: trig = pio_enable_export & ~en_q.
  - EN_MODE=1: trig = pio_enable_export ^ en_q.
  - en_q is a register of pio_enable_export.
- Push: on an edge with trig=1, pio_instruct_export is written to the FIFO tail in the same cycle.
  - If the FIFO is full and no pop occurs on that edge: the command is dropped, overflow pulses for 1 cycle, ERROR is set.
  - Simultaneous push and pop while full: the push succeeds and the count is unchanged.
- FIFO: circular buffer with wrap-around pointers; fifo_count = writes − reads.
- FULL flag = (fifo_count == DEPTH), registered.
- State machine, three states:
  - IDLE: go to ISSUE when the FIFO is non-empty.
  - ISSUE: cmd_valid=1 and cmd_data=head, both held stable until cmd_ready. On valid&ready: pop the head, go to WAIT.
  - WAIT: on cp_done go to ISSUE if the FIFO (after any same-cycle push) is non-empty, else go to IDLE.
  - WAIT timeout: when TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC without cp_done, set ERROR and go to IDLE. The counter clears on WAIT entry.
- Latency: from the first edge sampling trig=1 with the bridge idle and FIFO empty, cmd_valid is high after the 2nd edge (edge k push, edge k+1 IDLE→ISSUE).
- BUSY = (state != IDLE) | (fifo_count != 0).
- DONE: set on cp_done in WAIT; sticky.
- ERROR: set on overflow, on cp_done&cp_err in WAIT, or on timeout; sticky.
- Flag clearing: DONE and ERROR clear on any accepted push. When a set condition occurs in the same cycle as a clear, set wins.
- Ignored inputs: cp_done outside WAIT, and cp_err without cp_done.
- cmd_ready while cmd_valid=0: no effect.

Test Plan:
- Reset, then EN_MODE=0, instr=0x1ABCDEF, enable 0→1 → cmd_valid high 2 clocks later with cmd_data=0x1ABCDEF; cmd_ready=1 → WAIT; cp_done → flags=4'b0001.
- cmd_ready held 0, four triggers with DEPTH=4 → fifo_count=4, flags[2]=1; fifth trigger → overflow pulse, flags=4'b1110; drain all four → commands emerge in order 1..4 with none lost.
- EN_MODE=1, enable toggled 0→1→0→1 on separate cycles, ready=1, each done returned → three commands issued; enable held high produces no extra command.
- cp_done with cp_err=1 → flags[1]=1, DONE=1; next trigger clears both in the push cycle; cp_done pulse while in IDLE leaves flags unchanged.
- TIMEOUT_CYC=16, no cp_done → ERROR set 16 cycles after WAIT entry, state IDLE, BUSY=0 when the FIFO is empty.
- Reset asserted asynchronously with 3 queued and one in WAIT → outputs 0 immediately; after release, fifo_count=0 and no cmd_valid.
